face_overlay_writer: RTL and testbench
======================================

// Module: face_overlay_writer
// PURPOSE
//  Consumer end of a detection core's output: reads the 1-bit face mask and the original
//  grey-level tile (both in sync RAMs), streams the tile out with mask pixels forced to
//  OVERLAY_VAL, drawing the white detection boxes. Sits between each core and frame reassembly.
// PARAMETERS
//  PIX_W        8       pixel width
//  ADDR_W       17      tile address width (tiles up to 2^17 pixels, >= 100000)
//  OVERLAY_VAL  8'hFF   value written where mask==1
// PORTS
//  clk         in   1       clock
//  reset       in   1       async reset, active-low
//  start       in   1       1-cycle pulse, begin a tile pass (ignored while busy)
//  mode        in   1       0: overlay on image, 1: mask only (OVERLAY_VAL / 0); sampled at start
//  core_size   in   ADDR_W  pixels in tile, sampled at start
//  mem_rd      out  1       read strobe, shared by mask and pixel RAMs
//  mem_addr    out  ADDR_W  read address, shared
//  mask_data   in   1       mask RAM data, valid 1 cycle after mem_rd
//  pix_data    in   PIX_W   pixel RAM data, valid 1 cycle after mem_rd
//  out_valid   out  1       output pixel valid
//  out_ready   in   1       downstream accept
//  out_pixel   out  PIX_W   output pixel
//  out_index   out  ADDR_W  tile address of out_pixel
//  out_last    out  1       out_pixel is index core_size-1
//  busy        out  1       pass in progress
//  done        out  1       1-cycle pulse after final pixel accepted
//  face_count  out  ADDR_W  mask==1 pixels emitted this pass
// BEHAVIOUR
//  Reset: every output and all state 0; FSM to IDLE; FIFO flushed; in-flight read discarded.
//  FSM: IDLE -(start, core_size!=0)-> RUN; IDLE -(start, core_size==0)-> DONE (no reads, no output);
//   RUN -(last pixel handshaken)-> DONE; DONE -> IDLE after 1 cycle (done=1 only in DONE).
//  busy=1 in RUN and DONE. face_count cleared on accepted start, holds after done until next start.
//  Read issue: rd_ptr 0..core_size-1; mem_rd=1 in RUN while rd_ptr<core_size and
//   occ + inflight - pop < 2 (occ: FIFO entries, inflight: read issued last cycle, pop: out_valid&out_ready).
//  Read latency 1: data captured into 2-entry FIFO cycle after mem_rd, with its address.
//  Pixel: mode 0: mask ? OVERLAY_VAL : pix_data; mode 1: mask ? OVERLAY_VAL : 0.
//  Throughput: 1 pixel/cycle with out_ready held 1; first out_valid 2 cycles after start.
//  Handshake: valid/ready; out_* stable while out_valid & !out_ready; out_valid never drops unaccepted.
//  face_count += 1 on each handshake with mask==1; width ADDR_W, no overflow possible.
//  out_last=1 only with out_index==core_size-1.
//  start during RUN/DONE ignored, no effect on config or counters.
//  core_size==1: one read, one output with out_last=1.
//  Async reset mid-pass: immediate abort, no done pulse, next start begins a fresh pass.
// STRUCTURE
//  face_pkg: PIX_W, ADDR_W, OVERLAY_VAL defaults; state enum {IDLE,RUN,DONE}.
//  Sub-module overlay_skid_fifo: 2-entry FIFO, {addr, pixel, mask}, push/pop/occ, async
//   active-low reset. Top holds FSM, read pointer, credit logic, counters.
// TESTING
//  T1 core_size=4, mask=0110, pix=10,20,30,40, mode0, ready=1 -> out 10,FF,FF,40; idx 0..3;
//     out_last on idx3; done 1 cycle later; face_count=2.
//  T2 same data, mode1 -> out 00,FF,FF,00; face_count=2.
//  T3 core_size=16, random out_ready (50%) -> all 16 pixels in order, no dup/drop, out_* stable
//     under stall, occ never >2.
//  T4 core_size=0 start -> no mem_rd, no out_valid, done pulse; start with core_size=1 -> one pixel, out_last=1.
//  T5 start pulsed during RUN (core_size=8 then 3) -> 8 pixels only, one done.
//  T6 reset low at pixel 5 of 8 -> outputs 0 same cycle, no done; restart -> full 8-pixel pass, face_count recomputed.

Source files
------------

// File: rtl/face_overlay_writer_pkg.sv
`default_nettype none
// ============================================================
// face_pkg : shared defaults and FSM states for face_overlay_writer
// Rev 1.0
// ============================================================
package face_pkg;

  localparam int              PIX_W       = 8;
  localparam int              ADDR_W      = 17;
  localparam logic [7:0]      OVERLAY_VAL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/overlay_skid_fifo.sv
`default_nettype none
// ============================================================
// overlay_skid_fifo : 2-entry FIFO holding {addr, pixel, mask}
// Rev 1.0
// ============================================================
module overlay_skid_fifo #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  logic [W-1:0] r_mem [0:1];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({push, pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign head = r_mem[r_rd_ptr];
  assign occ  = r_occ;

endmodule
`default_nettype wire

// File: rtl/face_overlay_writer.sv
`default_nettype none
// ============================================================
// face_overlay_writer : streams a tile with mask pixels forced to OVERLAY_VAL
// Rev 1.0
// ============================================================
module face_overlay_writer #(
  parameter int                 PIX_W       = face_pkg::PIX_W,
  parameter int                 ADDR_W      = face_pkg::ADDR_W,
  parameter logic [PIX_W-1:0]   OVERLAY_VAL = face_pkg::OVERLAY_VAL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] core_size,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mask_data,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_pixel,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] face_count
);

  import face_pkg::*;

  localparam int c_ENT_W = ADDR_W + PIX_W + 1;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_mode;
  logic [ADDR_W-1:0]   r_size;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic                r_inflight;
  logic [ADDR_W-1:0]   r_inflight_addr;
  logic [ADDR_W-1:0]   r_face_count;

  logic                w_accept;
  logic                w_pop;
  logic                w_rd_ok;
  logic [2:0]          w_credit;
  logic [c_ENT_W-1:0]  w_head;
  logic [1:0]          w_occ;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [PIX_W-1:0]    w_head_pix;
  logic                w_head_mask;

  overlay_skid_fifo #(
    .W(c_ENT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (r_inflight),
    .push_data ({r_inflight_addr, pix_data, mask_data}),
    .pop       (w_pop),
    .head      (w_head),
    .occ       (w_occ)
  );

  assign w_head_addr = w_head[c_ENT_W-1 -: ADDR_W];
  assign w_head_pix  = w_head[PIX_W:1];
  assign w_head_mask = w_head[0];

  assign out_valid = (w_occ != 2'd0);
  assign w_pop     = out_valid & out_ready;
  assign out_index = out_valid ? w_head_addr : '0;
  assign out_last  = out_valid && (w_head_addr == (r_size - ADDR_W'(1)));
  assign out_pixel = !out_valid ? '0 :
                     w_head_mask ? OVERLAY_VAL :
                     r_mode ? '0 : w_head_pix;

  // A slot is free if buffered plus in-flight entries, less the one leaving now, stay under 2.
  assign w_credit = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_rd_ok  = w_credit < (3'd2 + {2'b00, w_pop});
  assign mem_rd   = (r_state == RUN) && (r_rd_ptr < r_size) && w_rd_ok;
  assign mem_addr = r_rd_ptr;

  assign w_accept   = (r_state == IDLE) && start;
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign face_count = r_face_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = (core_size != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (w_pop && out_last) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode          <= 1'b0;
      r_size          <= '0;
      r_rd_ptr        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
      r_face_count    <= '0;
    end else begin
      if (w_accept) begin
        r_mode       <= mode;
        r_size       <= core_size;
        r_rd_ptr     <= '0;
        r_face_count <= '0;
      end else begin
        if (mem_rd) begin
          r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        end
        if (w_pop && w_head_mask) begin
          r_face_count <= r_face_count + ADDR_W'(1);
        end
      end
      r_inflight      <= mem_rd;
      r_inflight_addr <= r_rd_ptr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_face_overlay_writer.sv
`default_nettype none
// ============================================================
// tb_face_overlay_writer : scoreboard bench for face_overlay_writer
// Rev 1.0
// ============================================================
module tb_face_overlay_writer;

  typedef struct packed {
    logic [16:0] idx;
    logic [7:0]  pix;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [16:0] core_size = '0;
  logic        mem_rd;
  logic [16:0] mem_addr;
  logic        mask_data;
  logic [7:0]  pix_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_pixel;
  logic [16:0] out_index;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [16:0] face_count;

  logic        mask_mem [0:15];
  logic [7:0]  pix_mem  [0:15];

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          pops = 0;
  int          cur_size = 0;
  int          exp_face = 0;
  int          last_cyc = 0;
  bit          saw_last = 0;
  bit          rnd_ready = 0;

  face_overlay_writer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .core_size  (core_size),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mask_data  (mask_data),
    .pix_data   (pix_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .face_count (face_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) begin
      mask_data <= mask_mem[mem_addr[3:0]];
      pix_data  <= pix_mem[mem_addr[3:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard compare, stall stability, read range, done timing
  initial begin
    exp_t   e;
    bit     prev_stall = 0;
    logic [7:0]  stall_pix = '0;
    logic [16:0] stall_idx = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        prev_stall = 0;
      end else begin
        if (mem_rd) begin
          rd_cnt++;
          chk("rd_range", 32'(int'(mem_addr) < cur_size), 1);
        end
        if (prev_stall) begin
          chk("stall_valid", 32'(out_valid), 1);
          chk("stall_pix", 32'(out_pixel), 32'(stall_pix));
          chk("stall_idx", 32'(out_index), 32'(stall_idx));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("extra_out", 1, 0);
          end else begin
            e = q.pop_front();
            chk("pix", 32'(out_pixel), 32'(e.pix));
            chk("idx", 32'(out_index), 32'(e.idx));
            chk("last", 32'(out_last), 32'(e.last));
            pops++;
            if (out_last) begin
              saw_last = 1;
              last_cyc = cyc;
            end
          end
        end
        if (done) begin
          done_cnt++;
          if (saw_last) chk("done_lat", 32'(cyc - last_cyc), 1);
          saw_last = 0;
        end
        prev_stall = out_valid && !out_ready;
        stall_pix  = out_pixel;
        stall_idx  = out_index;
      end
    end
  end

  task automatic fill_exp(input int size, input bit md);
    exp_t e;
    exp_face = 0;
    for (int i = 0; i < size; i++) begin
      e.idx  = 17'(i);
      e.pix  = mask_mem[i] ? 8'hFF : (md ? 8'h00 : pix_mem[i]);
      e.last = (i == size - 1);
      if (mask_mem[i]) exp_face++;
      q.push_back(e);
    end
  endtask

  task automatic run_pass(input int size, input bit md, input bit rnd, input int poke, input bit lat);
    int d0;
    int r0;
    int n;
    rnd_ready = rnd;
    fill_exp(size, md);
    d0 = done_cnt;
    r0 = rd_cnt;
    @(posedge clk);
    #1;
    cur_size  = size;
    core_size = 17'(size);
    mode      = md;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (lat) begin
      chk("lat0", 32'(out_valid), 0);
      @(posedge clk);
      #1;
      chk("lat1", 32'(out_valid), 0);
      @(posedge clk);
      #1;
      chk("lat2", 32'(out_valid), 1);
    end
    if (poke > 0) begin
      repeat (2) @(posedge clk);
      #1;
      core_size = 17'(poke);
      mode      = ~md;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) chk("timeout", 0, 1);
    @(posedge clk);
    #1;
    rnd_ready = 0;
    chk("drained", 32'(q.size()), 0);
    chk("done_cnt", 32'(done_cnt - d0), 1);
    chk("reads", 32'(rd_cnt - r0), 32'(size));
    chk("faces", 32'(face_count), 32'(exp_face));
    chk("busy_end", 32'(busy), 0);
  endtask

  initial begin
    int n;
    int d0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd", 32'(mem_rd), 0);
    chk("rst_faces", 32'(face_count), 0);
    chk("rst_pix", 32'(out_pixel), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // T1/T2: four-pixel tile, overlay then mask-only
    pix_mem[0] = 8'h10; pix_mem[1] = 8'h20; pix_mem[2] = 8'h30; pix_mem[3] = 8'h40;
    mask_mem[0] = 1'b0; mask_mem[1] = 1'b1; mask_mem[2] = 1'b1; mask_mem[3] = 1'b0;
    run_pass(4, 1'b0, 1'b0, 0, 1'b1);
    chk("t1_faces", 32'(face_count), 2);
    run_pass(4, 1'b1, 1'b0, 0, 1'b0);
    chk("t2_faces", 32'(face_count), 2);

    // T3: sixteen random pixels with random backpressure
    for (int i = 0; i < 16; i++) begin
      pix_mem[i]  = 8'($urandom);
      mask_mem[i] = 1'($urandom_range(0, 1));
    end
    run_pass(16, 1'b0, 1'b1, 0, 1'b0);

    // T4: empty tile, then single-pixel tile
    run_pass(0, 1'b0, 1'b0, 0, 1'b0);
    run_pass(1, 1'b0, 1'b0, 0, 1'b0);

    // T5: start re-pulsed mid-pass must be ignored
    run_pass(8, 1'b0, 1'b0, 3, 1'b0);

    // T6: asynchronous reset mid-pass, then a clean rerun
    for (int i = 0; i < 8; i++) mask_mem[i] = (i % 3 == 0);
    fill_exp(8, 1'b0);
    d0 = done_cnt;
    pops = 0;
    @(posedge clk);
    #1;
    cur_size  = 8;
    core_size = 17'd8;
    mode      = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (pops < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("t6_timeout", 0, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_rd", 32'(mem_rd), 0);
    chk("t6_faces", 32'(face_count), 0);
    chk("t6_pix", 32'(out_pixel), 0);
    q.delete();
    saw_last = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_nodone", 32'(done_cnt - d0), 0);
    reset = 1'b1;
    run_pass(8, 1'b0, 1'b0, 0, 1'b0);
    chk("t6_refaces", 32'(face_count), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
